mc_ctrl_fsm: RTL

- Main control state machine for the multicycle MIPS CPU.
- Sequences the shared datapath (single memory, single ALU, IR, PC, register file) through fetch/decode/execute/memory/writeback steps per instruction.
- Sits inside the cpu top beside the ALU decoder; consumes the IR opcode, drives all datapath enables and mux selects.
- Adds a memory-ready wait handshake with a timeout counter.

---
 rtl/mc_ctrl_fsm_if.sv | 34 +++
 rtl/mc_ctrl_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multicycle MIPS control FSM and its datapath.
// master = control FSM side, slave = datapath side.
interface mc_ctrl_fsm_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] op;
  logic           zero;
  logic           mem_ready;
  logic           pcen;
  logic           irwrite;
  logic           regwrite;
  logic           memwrite;
  logic           iord;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsrc;
  logic           regdst;
  logic           memtoreg;
  logic [1:0]     aluop;
  logic           illegal_op;
  logic           mem_err;

  modport master (
    input  op, zero, mem_ready,
    output pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb,
           pcsrc, regdst, memtoreg, aluop, illegal_op, mem_err
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb,
           pcsrc, regdst, memtoreg, aluop, illegal_op, mem_err
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS CPU, with mem_ready wait/timeout handling.
// Optional macro MC_BNE_EN adds bne (op 0x05) support via a BNEEX state.
module mc_ctrl_fsm #(
  parameter int OPW         = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'h05);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'h23);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'h2B);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MC_BNE_EN
    , S_BNEEX = 4'd12
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_illegal;
  logic [7:0] r_wait_cnt;
  logic       r_illegal_op;
  logic       r_mem_err;
  logic       w_waiting;
  logic       w_timeout;

  logic       w_pcen, w_irwrite, w_regwrite, w_memwrite;
  logic       w_iord, w_alusrca, w_regdst, w_memtoreg;
  logic [1:0] w_alusrcb, w_pcsrc, w_aluop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:   if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if      (bus.op == OP_LW || bus.op == OP_SW) w_next = S_MEMADR;
        else if (bus.op == OP_RTYPE)                 w_next = S_RTYPEEX;
        else if (bus.op == OP_BEQ)                   w_next = S_BEQEX;
        else if (bus.op == OP_ADDI)                  w_next = S_ADDIEX;
        else if (bus.op == OP_J)                     w_next = S_JEX;
`ifdef MC_BNE_EN
        else if (bus.op == OP_BNE)                   w_next = S_BNEEX;
`endif
        else begin
          w_next    = S_FETCH;
          w_illegal = 1'b1;
        end
      end
      S_MEMADR:  w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) w_next = S_MEMWB;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   if (bus.mem_ready) w_next = S_FETCH;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_RTYPEWB: w_next = S_FETCH;
      S_BEQEX:   w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JEX:     w_next = S_FETCH;
`ifdef MC_BNE_EN
      S_BNEEX:   w_next = S_FETCH;
`endif
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcen     = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_iord     = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_aluop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = bus.mem_ready;
        w_pcen    = bus.mem_ready;
      end
      S_DECODE:  w_alusrcb = 2'b11;
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD:   w_iord = 1'b1;
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_pcen    = bus.zero;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB:  w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc = 2'b10;
        w_pcen  = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_pcen    = ~bus.zero;
      end
`endif
      default: ;
    endcase
  end

  // A completing access (mem_ready) always beats a timeout in the same cycle.
  assign w_waiting = (r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR)
                     && !bus.mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt   <= '0;
      r_illegal_op <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_wait_cnt <= '0;
        r_mem_err  <= 1'b1;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_illegal) r_illegal_op <= 1'b1;
    end
  end

  assign bus.pcen       = w_pcen     & ~reset;
  assign bus.irwrite    = w_irwrite  & ~reset;
  assign bus.regwrite   = w_regwrite & ~reset;
  assign bus.memwrite   = w_memwrite & ~reset;
  assign bus.iord       = w_iord;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.aluop      = w_aluop;
  assign bus.illegal_op = r_illegal_op;
  assign bus.mem_err    = r_mem_err;

endmodule
